prefetch_issue_arbiter: RTL

// - Shares the single memory/DMA request port between demand misses and stream-prefetcher requests.
// - Queues prefetch addresses from stream_prefetcher and drops duplicates and overflow.
// - Demand misses have strict priority; a queued prefetch that a demand miss covers is cancelled.
// - Limits in-flight prefetches so prefetch traffic cannot saturate memory. Sits between the

---
 rtl/pf_arb_pkg.sv | 24 ++
 rtl/pf_req_fifo.sv | 113 +++++++++++
 rtl/prefetch_issue_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pf_arb_pkg
// Description : Shared types and defaults for the prefetch issue arbiter.
//               This covers the FSM state encoding, the line-address type and
//               the default address/line geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package pf_arb_pkg;

    localparam int DEF_ADDR_W        = 32;
    localparam int DEF_LINE_OFFSET_W = 6;

    // Line address at default geometry (byte address with offset bits removed)
    typedef logic [DEF_ADDR_W-DEF_LINE_OFFSET_W-1:0] line_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_REQ_DEMAND = 2'd1,
        ST_REQ_PF     = 2'd2
    } state_t;

endpackage : pf_arb_pkg
`default_nettype wire

// File: rtl/pf_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pf_req_fifo
// Description : Circular prefetch line queue. Each entry has a valid bit.
//               A parallel line compare (over valid entries) supports dedup.
//               A parallel match-invalidate supports cancel. A cancelled entry
//               keeps its slot until the consumer pops it.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_req_fifo #(
    parameter int LINE_W = 26,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [LINE_W-1:0]        push_line_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     cancel_i,
    input  logic [LINE_W-1:0]        cancel_line_i,
    input  logic [LINE_W-1:0]        match_line_i,
    output logic                     match_o,
    output logic                     head_valid_o,
    output logic [LINE_W-1:0]        head_line_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LINE_W-1:0] lines_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    logic w_do_push;
    logic w_do_pop;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign count_o      = count_q;
    assign head_valid_o = valid_q[head_q];
    assign head_line_o  = lines_q[head_q];

    // Fullness is the pre-pop value, so a push into a full queue is refused
    // even when the head leaves in the same cycle.
    assign w_do_push = push_i && !full_o && !flush_i;
    assign w_do_pop  = pop_i && !empty_o && !flush_i;

    // Dedup compare against every live entry
    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (lines_q[i] == match_line_i)) begin
                match_o = 1'b1;
            end
        end
    end

    // Next valid bits: cancel by line, then retire the head, then add the tail
    always_comb begin
        valid_d = valid_q;
        if (cancel_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (lines_q[i] == cancel_line_i) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (w_do_pop) begin
            valid_d[head_q] = 1'b0;
        end
        if (w_do_push) begin
            valid_d[tail_q] = 1'b1;
        end
    end

    // Pointer, count and valid state; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (w_do_push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Line storage needs no reset; the valid bits gate every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            lines_q[tail_q] <= push_line_i;
        end
    end

endmodule : pf_req_fifo
`default_nettype wire

// File: rtl/prefetch_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_issue_arbiter
// Description : Shares one memory request port between demand misses and
//               queued stream prefetches. Demand misses have strict priority
//               and cancel queued prefetches on the same line. Duplicate and
//               overflowing prefetches are dropped and counted. The number of
//               in-flight prefetches is throttled.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_issue_arbiter
    import pf_arb_pkg::*;
#(
    parameter int ADDR_W             = DEF_ADDR_W,
    parameter int LINE_OFFSET_W      = DEF_LINE_OFFSET_W,
    parameter int FIFO_DEPTH         = 4,
    parameter int MAX_PF_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_v_i,
    input  logic [ADDR_W-1:0]             miss_addr_i,
    output logic                          miss_ready_o,
    input  logic                          pf_v_i,
    input  logic [ADDR_W-1:0]             pf_addr_i,
    input  logic                          flush_i,
    output logic                          mem_req_v_o,
    output logic [ADDR_W-1:0]             mem_req_addr_o,
    output logic                          mem_req_pf_o,
    input  logic                          mem_req_ready_i,
    input  logic                          mem_resp_v_i,
    input  logic                          mem_resp_pf_i,
    output logic [3:0]                    pf_outstanding_o,
    output logic [$clog2(FIFO_DEPTH):0]   pf_queue_count_o,
    output logic [15:0]                   pf_drop_cnt_o
);

    localparam int LINE_W = ADDR_W - LINE_OFFSET_W;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   req_line_q, req_line_d;
    logic                req_pf_q, req_pf_d;
    logic [3:0]          pf_out_q;
    logic [15:0]         drop_q;

    logic [LINE_W-1:0]   w_miss_line;
    logic [LINE_W-1:0]   w_pf_line;
    logic [LINE_W-1:0]   w_head_line;
    logic                w_match;
    logic                w_head_valid;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_cancel;
    logic                w_pf_take;
    logic                w_pf_dup;
    logic                w_push;
    logic                w_drop;
    logic                w_pf_room;
    logic                w_pf_issue;
    logic                w_pf_resp;
    logic                w_unused_offset;

    assign w_miss_line = miss_addr_i[ADDR_W-1:LINE_OFFSET_W];
    assign w_pf_line   = pf_addr_i[ADDR_W-1:LINE_OFFSET_W];

    // Byte-offset bits never take part in any line decision
    assign w_unused_offset = ^{miss_addr_i[LINE_OFFSET_W-1:0], pf_addr_i[LINE_OFFSET_W-1:0]};

    assign w_pf_room = (pf_out_q < 4'(MAX_PF_OUTSTANDING));

    // A prefetch is redundant if its line is already queued, already on the
    // request port, or is the demand miss presented this cycle.
    assign w_pf_take = pf_v_i && !flush_i;
    assign w_pf_dup  = w_match
                    || ((state_q != ST_IDLE) && (w_pf_line == req_line_q))
                    || (miss_v_i && (w_pf_line == w_miss_line));
    assign w_push    = w_pf_take && !w_full && !w_pf_dup;
    assign w_drop    = w_pf_take && (w_full || w_pf_dup);

    assign w_pf_issue = (state_q == ST_REQ_PF) && mem_req_ready_i;
    assign w_pf_resp  = mem_resp_v_i && mem_resp_pf_i;

    assign miss_ready_o     = (state_q == ST_IDLE) && miss_v_i;
    assign mem_req_v_o      = (state_q != ST_IDLE);
    assign mem_req_addr_o   = {req_line_q, {LINE_OFFSET_W{1'b0}}};
    assign mem_req_pf_o     = req_pf_q;
    assign pf_outstanding_o = pf_out_q;
    assign pf_drop_cnt_o    = drop_q;

    pf_req_fifo #(
        .LINE_W (LINE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push_i        (w_push),
        .push_line_i   (w_pf_line),
        .pop_i         (w_pop),
        .flush_i       (flush_i),
        .cancel_i      (w_cancel),
        .cancel_line_i (w_miss_line),
        .match_line_i  (w_pf_line),
        .match_o       (w_match),
        .head_valid_o  (w_head_valid),
        .head_line_o   (w_head_line),
        .empty_o       (w_empty),
        .full_o        (w_full),
        .count_o       (pf_queue_count_o)
    );

    // Arbitration: demand first, then a throttled prefetch, else skip a cancelled head
    always_comb begin
        state_d    = state_q;
        req_line_d = req_line_q;
        req_pf_d   = req_pf_q;
        w_pop      = 1'b0;
        w_cancel   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_v_i) begin
                    state_d    = ST_REQ_DEMAND;
                    req_line_d = w_miss_line;
                    req_pf_d   = 1'b0;
                    w_cancel   = 1'b1;
                end else if (!w_empty) begin
                    if (!w_head_valid) begin
                        w_pop = 1'b1;
                    end else if (w_pf_room && !flush_i) begin
                        w_pop      = 1'b1;
                        state_d    = ST_REQ_PF;
                        req_line_d = w_head_line;
                        req_pf_d   = 1'b1;
                    end
                end
            end
            ST_REQ_DEMAND, ST_REQ_PF: begin
                if (mem_req_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request register; reset abandons any pending request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_line_q <= '0;
            req_pf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_line_q <= req_line_d;
            req_pf_q   <= req_pf_d;
        end
    end

    // In-flight prefetch count; simultaneous issue and response cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pf_out_q <= '0;
        end else if (w_pf_issue && !w_pf_resp) begin
            pf_out_q <= pf_out_q + 4'd1;
        end else if (!w_pf_issue && w_pf_resp && (pf_out_q != 4'd0)) begin
            pf_out_q <= pf_out_q - 4'd1;
        end
    end

    // Saturating count of dropped prefetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (w_drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

endmodule : prefetch_issue_arbiter
`default_nettype wire
